// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: controller state
// encoding, the BCD nibble type and the per-decade saturation helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Clamp a raw nibble into the legal BCD range (10..15 become 9).
    function automatic bcd_t bcd_sat(input bcd_t n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade of the stopwatch counter. The decade moves only when the
// global step is active and every lower decade is at its rollover value
// (carry_in). carry_out is combinational so a carry or borrow ripples through
// all decades within a single step.
module bcd_decade
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  bcd_t load_nibble,
    input  logic step,
    input  logic count_down,
    input  logic carry_in,
    output bcd_t nibble,
    output logic carry_out
);

    bcd_t nibble_q;

    assign nibble    = nibble_q;
    assign carry_out = carry_in && (count_down ? (nibble_q == 4'd0) : (nibble_q == BCD_MAX));

    // Decade register: reset, then preset load, then counting step.
    always_ff @(posedge clk) begin
        if (reset) begin
            nibble_q <= '0;
        end else if (load) begin
            nibble_q <= bcd_sat(load_nibble);
        end else if (step && carry_in) begin
            if (count_down) begin
                nibble_q <= (nibble_q == 4'd0) ? BCD_MAX : nibble_q - 4'd1;
            end else begin
                nibble_q <= (nibble_q == BCD_MAX) ? 4'd0 : nibble_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// Multi-decade BCD stopwatch with prescaler, up/down counting, preset load
// and DONE detection on count-down to zero.
// Optional lap freeze of the display output is built when the macro
// STOPWATCH_LAP_EN is defined; without it display_digits mirrors digits.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    count_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [4*NUM_DIGITS-1:0] display_digits,
    output logic                    tick,
    output logic                    overflow,
    output logic                    done
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] CNT_ONE   = DW'(1);

    sw_state_e         state_q;
    logic              dir_q;
    logic [PW-1:0]     presc_q;
    logic              tick_q;
    logic              ovf_q;
    logic [DW-1:0]     digits_w;
    logic [NUM_DIGITS:0] carry;
    logic              at_max;
    logic              step;
    logic              cnt_zero;
    logic              cnt_one;

    // A step happens on the prescaler wrap in RUN; a coincident load wins.
    assign at_max   = (presc_q == PRESC_MAX);
    assign step     = (state_q == RUN) && at_max && !load;
    assign cnt_zero = (digits_w == '0);
    assign cnt_one  = (digits_w == CNT_ONE);
    assign carry[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_decade
            bcd_decade u_decade (
                .clk         (clk),
                .reset       (reset),
                .load        (load),
                .load_nibble (load_value[4*g +: 4]),
                .step        (step),
                .count_down  (dir_q),
                .carry_in    (carry[g]),
                .nibble      (digits_w[4*g +: 4]),
                .carry_out   (carry[g+1])
            );
        end
    endgenerate

    // Controller FSM with prescaler, latched direction and registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            tick_q <= step;
            ovf_q  <= step && !dir_q && carry[NUM_DIGITS];
            if (load) begin
                state_q <= IDLE;
                presc_q <= '0;
            end else begin
                case (state_q)
                    IDLE, PAUSE: begin
                        if (run) begin
                            if (count_down && cnt_zero) begin
                                state_q <= DONE;
                                presc_q <= '0;
                            end else begin
                                state_q <= RUN;
                                dir_q   <= count_down;
                            end
                        end
                    end
                    RUN: begin
                        presc_q <= at_max ? '0 : presc_q + PW'(1);
                        if (step && dir_q && cnt_one) begin
                            state_q <= DONE;
                            presc_q <= '0;
                        end else if (!run) begin
                            state_q <= PAUSE;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign digits   = digits_w;
    assign tick     = tick_q;
    assign overflow = ovf_q;
    assign done     = (state_q == DONE);

`ifdef STOPWATCH_LAP_EN
    logic          freeze_q;
    logic [DW-1:0] hold_q;

    // Lap freeze: each lap pulse toggles; entering freeze snapshots the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            freeze_q <= 1'b0;
            hold_q   <= '0;
        end else if (load) begin
            freeze_q <= 1'b0;
        end else if (lap) begin
            freeze_q <= !freeze_q;
            if (!freeze_q) begin
                hold_q <= digits_w;
            end
        end
    end

    assign display_digits = freeze_q ? hold_q : digits_w;
`else
    logic unused_lap;

    assign unused_lap     = lap;
    assign display_digits = digits_w;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch (NUM_DIGITS=4, TICK_DIV=4). Expected
// outputs are queued before the clock advances and compared afterwards.
module tb_bcd_stopwatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        count_down;
    logic        load;
    logic [15:0] load_value;
    logic        lap;
    logic [15:0] digits;
    logic [15:0] display_digits;
    logic        tick;
    logic        overflow;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [15:0] dig;
        logic [15:0] disp;
        logic        tk;
        logic        ov;
        logic        dn;
    } exp_t;

    exp_t sb[$];

    logic [15:0] d9, d13, d17;

    bcd_stopwatch #(.NUM_DIGITS(4), .TICK_DIV(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .count_down     (count_down),
        .load           (load),
        .load_value     (load_value),
        .lap            (lap),
        .digits         (digits),
        .display_digits (display_digits),
        .tick           (tick),
        .overflow       (overflow),
        .done           (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] dig, input logic [15:0] disp,
                              input logic tk, input logic ov, input logic dn);
        exp_t e;
        e.tag = tag; e.dig = dig; e.disp = disp; e.tk = tk; e.ov = ov; e.dn = dn;
        sb.push_back(e);
    endtask

    task automatic sample_out();
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: no expectation queued");
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (digits === e.dig) else begin
            miscompares++;
            $error("FAIL %s digits: got %h expected %h", e.tag, digits, e.dig);
        end
        vectors++;
        assert (display_digits === e.disp) else begin
            miscompares++;
            $error("FAIL %s display_digits: got %h expected %h", e.tag, display_digits, e.disp);
        end
        vectors++;
        assert (tick === e.tk) else begin
            miscompares++;
            $error("FAIL %s tick: got %b expected %b", e.tag, tick, e.tk);
        end
        vectors++;
        assert (overflow === e.ov) else begin
            miscompares++;
            $error("FAIL %s overflow: got %b expected %b", e.tag, overflow, e.ov);
        end
        vectors++;
        assert (done === e.dn) else begin
            miscompares++;
            $error("FAIL %s done: got %b expected %b", e.tag, done, e.dn);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load       = 1'b1;
        load_value = v;
        clk_n(1);
        load       = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; count_down = 1'b0; load = 1'b0;
        load_value = '0; lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
        d9 = 16'h0003; d13 = 16'h0003; d17 = 16'h0006;
`else
        d9 = 16'h0005; d13 = 16'h0006; d17 = 16'h0007;
`endif

        // reset state
        expect_out("reset", 16'h0000, 16'h0000, 0, 0, 0);
        clk_n(2); sample_out();

        // basic up-count: one edge to enter RUN, then a step every 4 edges
        reset = 1'b0; run = 1'b1; count_down = 1'b0;
        expect_out("up_pre", 16'h0000, 16'h0000, 0, 0, 0);
        clk_n(4); sample_out();
        expect_out("up_1", 16'h0001, 16'h0001, 1, 0, 0);
        clk_n(1); sample_out();
        expect_out("up_tickoff", 16'h0001, 16'h0001, 0, 0, 0);
        clk_n(1); sample_out();
        expect_out("up_2", 16'h0002, 16'h0002, 1, 0, 0);
        clk_n(3); sample_out();
        expect_out("up_3", 16'h0003, 16'h0003, 1, 0, 0);
        clk_n(4); sample_out();

        // full ripple carry 0999 -> 1000
        run = 1'b0;
        expect_out("ld_0999", 16'h0999, 16'h0999, 0, 0, 0);
        do_load(16'h0999); sample_out();
        run = 1'b1;
        expect_out("ripple_pre", 16'h0999, 16'h0999, 0, 0, 0);
        clk_n(4); sample_out();
        expect_out("ripple", 16'h1000, 16'h1000, 1, 0, 0);
        clk_n(1); sample_out();

        // wrap from all 9s with overflow, still running afterwards
        run = 1'b0;
        expect_out("ld_9999", 16'h9999, 16'h9999, 0, 0, 0);
        do_load(16'h9999); sample_out();
        run = 1'b1;
        expect_out("ovf", 16'h0000, 16'h0000, 1, 1, 0);
        clk_n(5); sample_out();
        expect_out("ovf_off", 16'h0000, 16'h0000, 0, 0, 0);
        clk_n(1); sample_out();
        expect_out("wrap_run", 16'h0001, 16'h0001, 1, 0, 0);
        clk_n(3); sample_out();

        // illegal nibbles saturate to 9
        run = 1'b0;
        expect_out("sat", 16'h9395, 16'h9395, 0, 0, 0);
        do_load(16'hF3A5); sample_out();

        // count down to zero; direction change during RUN ignored
        count_down = 1'b1;
        do_load(16'h0002);
        run = 1'b1;
        clk_n(2);
        count_down = 1'b0;
        expect_out("dn_1", 16'h0001, 16'h0001, 1, 0, 0);
        clk_n(3); sample_out();
        expect_out("dn_0", 16'h0000, 16'h0000, 1, 0, 1);
        clk_n(4); sample_out();
        expect_out("done_hold", 16'h0000, 16'h0000, 0, 0, 1);
        clk_n(8); sample_out();
        run = 1'b0;
        expect_out("ld_exit", 16'h0005, 16'h0005, 0, 0, 0);
        do_load(16'h0005); sample_out();

        // full ripple borrow 1000 -> 0999
        do_load(16'h1000);
        run = 1'b1; count_down = 1'b1;
        expect_out("borrow", 16'h0999, 16'h0999, 1, 0, 0);
        clk_n(5); sample_out();

        // run with down-count at zero goes straight to DONE, no tick
        run = 1'b0;
        expect_out("ld_zero", 16'h0000, 16'h0000, 0, 0, 0);
        do_load(16'h0000); sample_out();
        run = 1'b1;
        expect_out("zero_done", 16'h0000, 16'h0000, 0, 0, 1);
        clk_n(1); sample_out();
        expect_out("zero_hold", 16'h0000, 16'h0000, 0, 0, 1);
        clk_n(4); sample_out();

        // pause holds the prescaler; first tick two edges after resume
        run = 1'b0; count_down = 1'b0;
        do_load(16'h0000);
        run = 1'b1;
        clk_n(3);
        run = 1'b0;
        clk_n(1);
        expect_out("pause_hold", 16'h0000, 16'h0000, 0, 0, 0);
        clk_n(10); sample_out();
        run = 1'b1;
        expect_out("resume_1", 16'h0000, 16'h0000, 0, 0, 0);
        clk_n(1); sample_out();
        expect_out("resume_2", 16'h0001, 16'h0001, 1, 0, 0);
        clk_n(1); sample_out();

        // lap freeze (or lap ignored when the feature is not built)
        run = 1'b0;
        do_load(16'h0003);
        run = 1'b1;
        clk_n(1);
        lap = 1'b1;
        clk_n(1);
        lap = 1'b0;
        expect_out("lap_mid", 16'h0005, d9, 1, 0, 0);
        clk_n(7); sample_out();
        expect_out("lap_frz", 16'h0006, d13, 1, 0, 0);
        clk_n(4); sample_out();
        lap = 1'b1;
        expect_out("lap_rel", 16'h0006, 16'h0006, 0, 0, 0);
        clk_n(1); sample_out();
        clk_n(1);
        lap = 1'b0;
        expect_out("lap_frz2", 16'h0007, d17, 1, 0, 0);
        clk_n(2); sample_out();

        // reset mid-RUN and mid-freeze clears everything
        reset = 1'b1;
        expect_out("lap_rst", 16'h0000, 16'h0000, 0, 0, 0);
        clk_n(1); sample_out();
        reset = 1'b0; run = 1'b0;

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
